// File: rtl/vcve2_dmem_arbiter.sv
// Shares one OBI data-memory port between the scalar LSU (port 0) and the VRF (port 1).
// Latency: request/grant path is zero-latency combinational; responses are routed by an owner-ID FIFO.
// Backpressure: a stalled request is held on its owner until granted; issue stops while the owner FIFO is full.
module vcve2_dmem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,

    input  logic        vrf_req_i,
    input  logic        vrf_we_i,
    input  logic [3:0]  vrf_be_i,
    input  logic [31:0] vrf_addr_i,
    input  logic [31:0] vrf_wdata_i,
    output logic        vrf_gnt_o,
    output logic        vrf_rvalid_o,
    output logic        vrf_err_o,
    output logic [31:0] vrf_rdata_o,

    input  logic        vrf_lock_i,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,

    output logic        busy_o,
    output logic        proto_err_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    localparam logic            PortLsu = 1'b0;
    localparam logic            PortVrf = 1'b1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       proto_err_q, proto_err_d;

    logic [MaxOutstanding-1:0] mem_q, mem_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;

    logic sel;
    logic sel_req;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic head;

    // Pointers wrap modulo the FIFO depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    assign fifo_full  = (cnt_q == CntMax);
    assign fifo_empty = (cnt_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // Pick the port driving the memory request: a stalled request keeps its owner, lock forces VRF.
    always_comb begin
        sel = PortLsu;
        if (state_q == ARB_HOLD) begin
            sel = owner_q;
        end else if (vrf_lock_i) begin
            sel = PortVrf;
        end else if (lsu_req_i && vrf_req_i) begin
            sel = ~last_q;
        end else if (vrf_req_i) begin
            sel = PortVrf;
        end else begin
            sel = PortLsu;
        end
    end

    // Request mux and grant steering; no bypass when full, so a same-cycle pop does not free a slot.
    always_comb begin
        sel_req      = (sel == PortVrf) ? vrf_req_i : lsu_req_i;
        data_req_o   = sel_req & ~fifo_full;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (data_req_o) begin
            if (sel == PortVrf) begin
                data_we_o    = vrf_we_i;
                data_be_o    = vrf_be_i;
                data_addr_o  = vrf_addr_i;
                data_wdata_o = vrf_wdata_i;
            end else begin
                data_we_o    = lsu_we_i;
                data_be_o    = lsu_be_i;
                data_addr_o  = lsu_addr_i;
                data_wdata_o = lsu_wdata_i;
            end
        end
        lsu_gnt_o = data_req_o & data_gnt_i & (sel == PortLsu);
        vrf_gnt_o = data_req_o & data_gnt_i & (sel == PortVrf);
    end

    assign push = data_req_o & data_gnt_i;
    assign pop  = data_rvalid_i & ~fifo_empty;

    // Route the response to the FIFO head; orphan responses are dropped and flagged instead.
    always_comb begin
        lsu_rvalid_o = pop & (head == PortLsu);
        vrf_rvalid_o = pop & (head == PortVrf);
        lsu_err_o    = lsu_rvalid_o & data_err_i;
        vrf_err_o    = vrf_rvalid_o & data_err_i;
        lsu_rdata_o  = pop ? data_rdata_i : '0;
        vrf_rdata_o  = pop ? data_rdata_i : '0;
    end

    assign busy_o      = ~fifo_empty;
    assign proto_err_o = proto_err_q;

    // Next-state: arbitration FSM, round-robin history, owner FIFO and sticky protocol error.
    always_comb begin
        state_d     = (data_req_o && !data_gnt_i) ? ARB_HOLD : ARB_FREE;
        owner_d     = (data_req_o && !data_gnt_i) ? sel : owner_q;
        last_d      = push ? sel : last_q;
        proto_err_d = proto_err_q | (data_rvalid_i & fifo_empty);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards every outstanding owner ID and lets the LSU win the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ARB_FREE;
            owner_q     <= PortLsu;
            last_q      <= PortVrf;
            proto_err_q <= 1'b0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vcve2_dmem_arbiter.sv
// Directed bench for vcve2_dmem_arbiter with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Runs a fixed number of cycles and never waits on a DUT event.
module tb_vcve2_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i, lsu_we_i;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        vrf_req_i, vrf_we_i;
    logic [3:0]  vrf_be_i;
    logic [31:0] vrf_addr_i, vrf_wdata_i;
    logic        vrf_gnt_o, vrf_rvalid_o, vrf_err_o;
    logic [31:0] vrf_rdata_o;
    logic        vrf_lock_i;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;
    logic        busy_o, proto_err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    vcve2_dmem_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o),
        .lsu_rdata_o(lsu_rdata_o),
        .vrf_req_i(vrf_req_i), .vrf_we_i(vrf_we_i), .vrf_be_i(vrf_be_i),
        .vrf_addr_i(vrf_addr_i), .vrf_wdata_i(vrf_wdata_i),
        .vrf_gnt_o(vrf_gnt_o), .vrf_rvalid_o(vrf_rvalid_o), .vrf_err_o(vrf_err_o),
        .vrf_rdata_o(vrf_rdata_o),
        .vrf_lock_i(vrf_lock_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
        .data_rdata_i(data_rdata_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Move to the falling edge so combinational outputs have settled.
    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_addr_i = 32'h0000_0200; lsu_wdata_i = 32'h1111_1111;
        vrf_req_i = 0; vrf_we_i = 0; vrf_be_i = 4'h3; vrf_addr_i = 32'h0000_0800; vrf_wdata_i = 32'h2222_2222;
        vrf_lock_i = 0; data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        tick();
        tick();
        rst_ni = 1;
    endtask

    initial begin
        rst_ni = 0;
        do_reset();

        // Reset state: idle with stray read data on the bus still yields all-zero outputs.
        data_rdata_i = 32'hCAFE_F00D;
        mid();
        chk("rst_req",      data_req_o,   0);
        chk("rst_busy",     busy_o,       0);
        chk("rst_proto",    proto_err_o,  0);
        chk("rst_lsu_gnt",  lsu_gnt_o,    0);
        chk("rst_addr",     data_addr_o,  0);
        chk("rst_lsu_rd",   lsu_rdata_o,  0);
        chk("rst_vrf_rv",   vrf_rvalid_o, 0);
        tick();

        // 1: LSU read of 0x100, granted same cycle, answered next cycle.
        lsu_req_i = 1; lsu_addr_i = 32'h0000_0100; data_gnt_i = 1; data_rdata_i = 0;
        mid();
        chk("t1_req",     data_req_o,  1);
        chk("t1_addr",    data_addr_o, 32'h100);
        chk("t1_be",      data_be_o,   4'hF);
        chk("t1_lsu_gnt", lsu_gnt_o,   1);
        chk("t1_vrf_gnt", vrf_gnt_o,   0);
        tick();
        lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hDEAD_BEEF;
        mid();
        chk("t1_busy",    busy_o,       1);
        chk("t1_lsu_rv",  lsu_rvalid_o, 1);
        chk("t1_vrf_rv",  vrf_rvalid_o, 0);
        chk("t1_rdata",   lsu_rdata_o,  32'hDEAD_BEEF);
        chk("t1_err",     lsu_err_o,    0);
        tick();
        data_rvalid_i = 0;
        mid();
        chk("t1_idle",    busy_o,       0);

        // 2: both request, memory always grants; grants alternate LSU,VRF,... and responses follow issue order.
        do_reset();
        lsu_req_i = 1; lsu_we_i = 1; vrf_req_i = 1; data_gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            data_rvalid_i = (i > 0);
            data_rdata_i  = 32'h100 + i;
            data_err_i    = (i == 2);
            mid();
            chk($sformatf("t2_lsu_gnt%0d", i), lsu_gnt_o,    (i % 2) == 0);
            chk($sformatf("t2_vrf_gnt%0d", i), vrf_gnt_o,    (i % 2) == 1);
            chk($sformatf("t2_wdata%0d", i),   data_wdata_o, (i % 2) == 0 ? 32'h1111_1111 : 32'h2222_2222);
            chk($sformatf("t2_we%0d", i),      data_we_o,    (i % 2) == 0);
            if (i > 0) begin
                chk($sformatf("t2_lsu_rv%0d", i), lsu_rvalid_o, ((i - 1) % 2) == 0);
                chk($sformatf("t2_vrf_rv%0d", i), vrf_rvalid_o, ((i - 1) % 2) == 1);
            end
            tick();
        end
        chk("t2_vrf_err", vrf_err_o, 0);
        lsu_req_i = 0; vrf_req_i = 0; data_rvalid_i = 1; data_err_i = 1;
        mid();
        chk("t2_last_vrf_rv", vrf_rvalid_o, 1);
        chk("t2_last_vrf_er", vrf_err_o,    1);
        chk("t2_last_lsu_er", lsu_err_o,    0);
        tick();
        data_rvalid_i = 0; data_err_i = 0;
        mid();
        chk("t2_drained", busy_o, 0);

        // 3: lock gives VRF every grant; after lock drops the LSU wins the tie.
        do_reset();
        vrf_lock_i = 1; lsu_req_i = 1; vrf_req_i = 1; data_gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            data_rvalid_i = (i > 0);
            mid();
            chk($sformatf("t3_vrf_gnt%0d", i), vrf_gnt_o, 1);
            chk($sformatf("t3_lsu_gnt%0d", i), lsu_gnt_o, 0);
            tick();
        end
        vrf_lock_i = 0; data_rvalid_i = 1;
        mid();
        chk("t3_unlock_lsu", lsu_gnt_o,    1);
        chk("t3_unlock_vrf", vrf_gnt_o,    0);
        chk("t3_resp_vrf",   vrf_rvalid_o, 1);
        tick();
        lsu_req_i = 0; vrf_req_i = 0;
        mid();
        chk("t3_resp_lsu",   lsu_rvalid_o, 1);
        tick();
        data_rvalid_i = 0;

        // 4: a stalled LSU request is not retracted when the lock rises.
        do_reset();
        lsu_req_i = 1; data_gnt_i = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk($sformatf("t4_stall_req%0d", i), data_req_o, 1);
            tick();
        end
        vrf_lock_i = 1; vrf_req_i = 1;
        mid();
        chk("t4_held_addr", data_addr_o, 32'h200);
        chk("t4_held_vgnt", vrf_gnt_o,   0);
        tick();
        data_gnt_i = 1;
        mid();
        chk("t4_lsu_gnt",   lsu_gnt_o,   1);
        chk("t4_vrf_gnt",   vrf_gnt_o,   0);
        tick();
        lsu_req_i = 0;
        mid();
        chk("t4_then_vrf",  vrf_gnt_o,   1);
        chk("t4_vrf_addr",  data_addr_o, 32'h800);
        chk("t4_vrf_be",    data_be_o,   4'h3);
        tick();
        vrf_req_i = 0; vrf_lock_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
        mid();
        chk("t4_resp0_lsu", lsu_rvalid_o, 1);
        tick();
        mid();
        chk("t4_resp1_vrf", vrf_rvalid_o, 1);
        tick();
        data_rvalid_i = 0;

        // 5: FIFO full blocks issue, including the cycle of a pop; issue resumes next cycle.
        do_reset();
        lsu_req_i = 1; data_gnt_i = 1;
        tick();
        tick();
        mid();
        chk("t5_full_req",  data_req_o, 0);
        chk("t5_full_gnt",  lsu_gnt_o,  0);
        chk("t5_full_busy", busy_o,     1);
        tick();
        data_rvalid_i = 1;
        mid();
        chk("t5_nobypass",  data_req_o,   0);
        chk("t5_pop_rv",    lsu_rvalid_o, 1);
        tick();
        data_rvalid_i = 0;
        mid();
        chk("t5_reissue",   data_req_o, 1);
        chk("t5_regrant",   lsu_gnt_o,  1);
        tick();

        // 6: reset with two outstanding drops them; a later response is an orphan.
        lsu_req_i = 0; data_gnt_i = 0;
        mid();
        chk("t6_pre_busy",  busy_o, 1);
        rst_ni = 0;
        tick();
        rst_ni = 1;
        mid();
        chk("t6_post_busy", busy_o, 0);
        tick();
        data_rvalid_i = 1; data_rdata_i = 32'h5555_AAAA;
        mid();
        chk("t6_no_lsu_rv", lsu_rvalid_o, 0);
        chk("t6_no_vrf_rv", vrf_rvalid_o, 0);
        chk("t6_no_rdata",  lsu_rdata_o,  0);
        tick();
        data_rvalid_i = 0;
        mid();
        chk("t6_proto",     proto_err_o, 1);
        tick();
        tick();
        mid();
        chk("t6_sticky",    proto_err_o, 1);
        do_reset();
        mid();
        chk("t6_cleared",   proto_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
